// File: rtl/insn_fifo.sv
// rtl/insn_fifo.sv - first-word-fall-through instruction queue between fetch and execute
module insn_fifo #(
    parameter int WIDTH     = 24,
    parameter int ADDR_BITS = 2,
    parameter int AF_MARGIN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     ififo_di,
    input  logic                 ififo_shift,
    output logic                 ififo_full,
    output logic                 ififo_almost_full,
    input  logic                 flush,
    output logic [WIDTH-1:0]     exec_insn,
    output logic                 exec_valid,
    input  logic                 exec_take,
    output logic [ADDR_BITS:0]   ififo_level,
    output logic                 overflow
);
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int AF_THRESH = DEPTH - AF_MARGIN;
    localparam logic [ADDR_BITS:0] FULL_LVL = (ADDR_BITS+1)'(DEPTH);
    // A margin covering the whole queue pins almost-full high even when empty.
    localparam logic [ADDR_BITS:0] AF_LVL   = (AF_THRESH <= 0) ? '0 : (ADDR_BITS+1)'(AF_THRESH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 take_ok, push_ok, mem_we;

    assign exec_valid        = (level_q != '0);
    assign exec_insn         = exec_valid ? mem_q[rd_ptr_q] : '0;
    assign ififo_full        = (level_q == FULL_LVL);
    assign ififo_almost_full = (level_q >= AF_LVL);
    assign ififo_level       = level_q;
    assign overflow          = overflow_q;

    always_comb begin
        take_ok    = exec_take & exec_valid;
        push_ok    = ififo_shift & (~ififo_full | take_ok);
        mem_we     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (ififo_shift && !push_ok) begin
                overflow_d = 1'b1;
            end
            if (push_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (take_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, take_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is never cleared; exec_insn gating hides stale words.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= ififo_di;
        end
    end
endmodule

// File: tb/tb_insn_fifo.sv
// tb/tb_insn_fifo.sv - directed self-checking bench for insn_fifo
module tb_insn_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] ififo_di;
    logic        ififo_shift;
    logic        ififo_full;
    logic        ififo_almost_full;
    logic        flush;
    logic [23:0] exec_insn;
    logic        exec_valid;
    logic        exec_take;
    logic [2:0]  ififo_level;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    insn_fifo #(.WIDTH(24), .ADDR_BITS(2), .AF_MARGIN(1)) dut (
        .clk(clk), .reset(reset), .ififo_di(ififo_di), .ififo_shift(ififo_shift),
        .ififo_full(ififo_full), .ififo_almost_full(ififo_almost_full), .flush(flush),
        .exec_insn(exec_insn), .exec_valid(exec_valid), .exec_take(exec_take),
        .ififo_level(ififo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, sample 1 time unit after the edge.
    task automatic step(input logic sh, input logic [23:0] d, input logic tk, input logic fl);
        ififo_shift = sh;
        ififo_di    = d;
        exec_take   = tk;
        flush       = fl;
        @(posedge clk);
        #1;
        ififo_shift = 1'b0;
        exec_take   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; ififo_shift = 1'b0; ififo_di = '0; exec_take = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", exec_valid); end
        checks++; if (exec_insn !== 24'h0) begin errors++; $display("FAIL reset_insn got %h exp 000000", exec_insn); end
        checks++; if (ififo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", ififo_full); end
        checks++; if (ififo_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", ififo_almost_full); end
        checks++; if (ififo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", ififo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        reset = 1'b1;
    endtask

    task automatic test_fill;
        logic [23:0] words [4];
        words[0] = 24'hAAAAAA; words[1] = 24'h555555; words[2] = 24'h123456; words[3] = 24'hFF00FF;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, words[i], 1'b0, 1'b0);
            checks++; if (ififo_level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, ififo_level, i + 1); end
            checks++; if (exec_valid !== 1'b1 || exec_insn !== 24'hAAAAAA) begin errors++; $display("FAIL fill_head[%0d] got %b/%h exp 1/aaaaaa", i, exec_valid, exec_insn); end
            checks++; if (ififo_almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, ififo_almost_full, i >= 2); end
            checks++; if (ififo_full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, ififo_full, i == 3); end
        end
    endtask

    task automatic test_overflow;
        logic [23:0] words [4];
        words[0] = 24'hAAAAAA; words[1] = 24'h555555; words[2] = 24'h123456; words[3] = 24'hFF00FF;
        step(1'b1, 24'h777777, 1'b0, 1'b0);
        checks++; if (ififo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", ififo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (exec_insn !== 24'hAAAAAA) begin errors++; $display("FAIL ovf_head got %h exp aaaaaa", exec_insn); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (exec_insn !== words[i]) begin errors++; $display("FAIL ovf_order[%0d] got %h exp %h", i, exec_insn, words[i]); end
            step(1'b0, 24'h0, 1'b1, 1'b0);
        end
        checks++; if (exec_valid !== 1'b0 || exec_insn !== 24'h0) begin errors++; $display("FAIL ovf_empty got %b/%h exp 0/000000", exec_valid, exec_insn); end
    endtask

    task automatic test_pass_through;
        logic [23:0] exp_q [4];
        exp_q[0] = 24'h000002; exp_q[1] = 24'h000003; exp_q[2] = 24'h000004; exp_q[3] = 24'h0BEEF0;
        for (int i = 1; i <= 4; i++) step(1'b1, 24'(i), 1'b0, 1'b0);
        checks++; if (ififo_full !== 1'b1) begin errors++; $display("FAIL pt_full got %b exp 1", ififo_full); end
        step(1'b1, 24'h0BEEF0, 1'b1, 1'b0);
        checks++; if (ififo_level !== 3'd4) begin errors++; $display("FAIL pt_level got %0d exp 4", ififo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pt_ovf got %b exp 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (exec_insn !== exp_q[i]) begin errors++; $display("FAIL pt_order[%0d] got %h exp %h", i, exec_insn, exp_q[i]); end
            step(1'b0, 24'h0, 1'b1, 1'b0);
        end
        checks++; if (ififo_level !== 3'd0) begin errors++; $display("FAIL pt_drained got %0d exp 0", ififo_level); end
    endtask

    task automatic test_empty_corner;
        step(1'b1, 24'h5A5A5A, 1'b1, 1'b0);
        checks++; if (ififo_level !== 3'd1) begin errors++; $display("FAIL ec_level got %0d exp 1", ififo_level); end
        checks++; if (exec_insn !== 24'h5A5A5A) begin errors++; $display("FAIL ec_head got %h exp 5a5a5a", exec_insn); end
        step(1'b0, 24'h0, 1'b1, 1'b0);
        step(1'b0, 24'h0, 1'b1, 1'b0);
        checks++; if (ififo_level !== 3'd0 || exec_valid !== 1'b0) begin errors++; $display("FAIL ec_idle_take got %0d/%b exp 0/0", ififo_level, exec_valid); end
        step(1'b1, 24'h0C0C0C, 1'b0, 1'b0);
        checks++; if (exec_insn !== 24'h0C0C0C || ififo_level !== 3'd1) begin errors++; $display("FAIL ec_ptr got %h/%0d exp 0c0c0c/1", exec_insn, ififo_level); end
        step(1'b0, 24'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) step(1'b1, 24'h000031 + 24'(i), 1'b0, 1'b0);
        checks++; if (ififo_level !== 3'd3) begin errors++; $display("FAIL fl_pre got %0d exp 3", ififo_level); end
        step(1'b1, 24'h111111, 1'b1, 1'b1);
        checks++; if (ififo_level !== 3'd0) begin errors++; $display("FAIL fl_level got %0d exp 0", ififo_level); end
        checks++; if (exec_valid !== 1'b0 || exec_insn !== 24'h0) begin errors++; $display("FAIL fl_out got %b/%h exp 0/000000", exec_valid, exec_insn); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fl_ovf got %b exp 1", overflow); end
        step(1'b1, 24'h222222, 1'b0, 1'b0);
        checks++; if (exec_insn !== 24'h222222 || ififo_level !== 3'd1) begin errors++; $display("FAIL fl_after got %h/%0d exp 222222/1", exec_insn, ififo_level); end
        step(1'b0, 24'h0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        step(1'b1, 24'h000100, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            checks++; if (exec_insn !== 24'h000100 + 24'(i - 1)) begin errors++; $display("FAIL wrap_head[%0d] got %h exp %h", i, exec_insn, 24'h000100 + 24'(i - 1)); end
            step(1'b1, 24'h000100 + 24'(i), 1'b1, 1'b0);
            checks++; if (ififo_level !== 3'd1) begin errors++; $display("FAIL wrap_level[%0d] got %0d exp 1", i, ififo_level); end
        end
        checks++; if (exec_insn !== 24'h00010A) begin errors++; $display("FAIL wrap_last got %h exp 00010a", exec_insn); end
    endtask

    task automatic test_async_reset;
        step(1'b1, 24'h0DEAD0, 1'b0, 1'b0);
        checks++; if (ififo_level !== 3'd2) begin errors++; $display("FAIL ar_pre got %0d exp 2", ififo_level); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (exec_valid !== 1'b0 || exec_insn !== 24'h0) begin errors++; $display("FAIL ar_out got %b/%h exp 0/000000", exec_valid, exec_insn); end
        checks++; if (ififo_level !== 3'd0) begin errors++; $display("FAIL ar_level got %0d exp 0", ififo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_ovf got %b exp 0", overflow); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_pass_through();
        test_empty_corner();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
